// File: rtl/tft_pattern_gen.sv
// Self-timed test-pattern pixel source for the TFT MPU-interface path.
// Streams full frames over a valid/ready handshake, single-shot or continuous.
//
// state     | meaning
// IDLE      | waiting for a start request with non-zero geometry
// WAIT_INIT | configuration latched, holding until panel init completes
// RUN       | streaming pixels, one per accepted transfer
// DONE      | one-cycle gap after the final frame
module tft_pattern_gen #(
  parameter int MAX_HRES        = 512,
  parameter int MAX_VRES        = 1024,
  parameter int COLOR_PRECISION = 8,
  parameter int CHECKER_LOG2    = 3,
  parameter int FRAME_CNT_WIDTH = 16,
  localparam int HW = $clog2(MAX_HRES),
  localparam int VW = $clog2(MAX_VRES),
  localparam int CP = COLOR_PRECISION,
  localparam int PW = 3 * COLOR_PRECISION
) (
  input  logic                       i_sysclk,
  input  logic                       i_arstn,
  input  logic                       i_init_done,
  input  logic                       i_start,
  input  logic                       i_stop,
  input  logic                       i_continuous,
  input  logic [2:0]                 i_mode,
  input  logic [HW-1:0]              i_width,
  input  logic [VW-1:0]              i_height,
  input  logic [PW-1:0]              i_fg_rgb,
  input  logic [PW-1:0]              i_bg_rgb,
  input  logic                       i_ready,
  output logic                       o_de,
  output logic [PW-1:0]              o_rgb,
  output logic [HW-1:0]              o_x,
  output logic [VW-1:0]              o_y,
  output logic                       o_sof,
  output logic                       o_eof,
  output logic                       o_busy,
  output logic [FRAME_CNT_WIDTH-1:0] o_frame_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT_INIT, RUN, DONE} state_t;

  state_t state, state_next;

  logic [2:0]                 cfg_mode;
  logic [HW-1:0]              cfg_w;
  logic [VW-1:0]              cfg_h;
  logic [PW-1:0]              cfg_fg;
  logic [PW-1:0]              cfg_bg;
  logic                       cfg_cont;
  logic [HW-1:0]              bar_w;
  logic [HW-1:0]              x;
  logic [VW-1:0]              y;
  logic [HW-1:0]              bar_cnt;
  logic [3:0]                 bar_idx;
  logic                       stop_pending;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt;

  logic          geom_ok;
  logic          load_cfg;
  logic          xfer;
  logic          x_last;
  logic          y_last;
  logic          last_pix;
  logic [HW-1:0] bw_in;
  logic [PW-1:0] pix;
  logic [PW-1:0] bar_rgb;
  logic [CP-1:0] grey_x;
  logic [CP-1:0] grey_y;
  logic          border;

  assign geom_ok  = (i_width != '0) && (i_height != '0);
  assign xfer     = (state == RUN) && i_ready;
  assign x_last   = (x == cfg_w - HW'(1));
  assign y_last   = (y == cfg_h - VW'(1));
  assign last_pix = xfer && x_last && y_last;
  // Bar width is W/8, never below one column so the bar counter always advances.
  assign bw_in    = (i_width[HW-1:3] == '0) ? HW'(1) : (i_width >> 3);

  always_ff @(posedge i_sysclk or negedge i_arstn) begin
    if (!i_arstn) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_cfg   = 1'b0;
    case (state)
      IDLE: begin
        if (i_start && geom_ok) begin
          load_cfg   = 1'b1;
          state_next = i_init_done ? RUN : WAIT_INIT;
        end
      end
      WAIT_INIT: begin
        if (i_stop)           state_next = IDLE;
        else if (i_init_done) state_next = RUN;
      end
      RUN: begin
        if (last_pix) begin
          // A stop arriving on the final pixel still ends the stream here.
          if (cfg_cont && !stop_pending && !i_stop && geom_ok) load_cfg   = 1'b1;
          else                                                 state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_sysclk or negedge i_arstn) begin
    if (!i_arstn) begin
      cfg_mode     <= '0;
      cfg_w        <= '0;
      cfg_h        <= '0;
      cfg_fg       <= '0;
      cfg_bg       <= '0;
      cfg_cont     <= 1'b0;
      bar_w        <= '0;
      x            <= '0;
      y            <= '0;
      bar_cnt      <= '0;
      bar_idx      <= '0;
      stop_pending <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      if (state == RUN && i_stop) stop_pending <= 1'b1;
      if (last_pix) frame_cnt <= frame_cnt + FRAME_CNT_WIDTH'(1);
      if (load_cfg) begin
        cfg_mode     <= i_mode;
        cfg_w        <= i_width;
        cfg_h        <= i_height;
        cfg_fg       <= i_fg_rgb;
        cfg_bg       <= i_bg_rgb;
        cfg_cont     <= i_continuous;
        bar_w        <= bw_in;
        x            <= '0;
        y            <= '0;
        bar_cnt      <= bw_in - HW'(1);
        bar_idx      <= '0;
        stop_pending <= 1'b0;
      end else if (xfer) begin
        if (x_last) begin
          x       <= '0;
          y       <= y_last ? '0 : y + VW'(1);
          bar_cnt <= bar_w - HW'(1);
          bar_idx <= '0;
        end else begin
          x <= x + HW'(1);
          if (bar_cnt == '0) begin
            bar_cnt <= bar_w - HW'(1);
            if (bar_idx != 4'd8) bar_idx <= bar_idx + 4'd1;
          end else begin
            bar_cnt <= bar_cnt - HW'(1);
          end
        end
      end
    end
  end

  // Bar colour bits: R off for bars 2,3,6,7; G off for 4..7; B off for odd bars.
  assign bar_rgb = (bar_idx < 4'd8) ?
                   {{CP{~bar_idx[1]}}, {CP{~bar_idx[2]}}, {CP{~bar_idx[0]}}} : '0;
  assign grey_x  = CP'(x);
  assign grey_y  = CP'(y);
  assign border  = (x == '0) || x_last || (y == '0) || y_last;

  always_comb begin
    pix = cfg_bg;
    case (cfg_mode)
      3'd0:    pix = cfg_fg;
      3'd1:    pix = bar_rgb;
      3'd2:    pix = (x[CHECKER_LOG2] ^ y[CHECKER_LOG2]) ? cfg_fg : cfg_bg;
      3'd3:    pix = {3{grey_x}};
      3'd4:    pix = {3{grey_y}};
      3'd5:    pix = border ? cfg_fg : cfg_bg;
      default: pix = cfg_bg;
    endcase
  end

  assign o_de        = (state == RUN);
  assign o_rgb       = o_de ? pix : '0;
  assign o_x         = x;
  assign o_y         = y;
  assign o_sof       = o_de && (x == '0) && (y == '0);
  assign o_eof       = o_de && x_last && y_last;
  assign o_busy      = (state != IDLE);
  assign o_frame_cnt = frame_cnt;

endmodule
